// File: rtl/freq_div_pkg.sv
// Shared definitions for the freq_div output monitor: channel FSM encoding and channel indices.
// No logic, no latency.
// No flow control.
package freq_div_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam int CH_50 = 0;
    localparam int CH_10 = 1;
    localparam int CH_1  = 2;
    localparam int N_CH  = 3;

endpackage

// File: rtl/freq_div_chan_mon.sv
// One divided-clock channel: measures CLK_in cycles between transitions and tracks good/fault status.
// err is registered state; lock_nxt is the combinational next-cycle lock term for the top register.
// No backpressure: one sample accepted every CLK_in cycle.
module freq_div_chan_mon
    import freq_div_pkg::*;
#(
    parameter int HP     = 5,
    parameter int LOCK_N = 4,
    parameter int CW     = 8
) (
    input  logic          CLK_in,
    input  logic          RST,
    input  logic          div_clk,
    input  logic          CLR,
    output logic          err,
    output logic          lock_nxt,
    output logic [CW-1:0] last_meas
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam logic [CW-1:0] HP_V    = CW'(HP);
    localparam logic [CW-1:0] HP1_V   = CW'(HP + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);

    mon_state_t    state, state_nxt;
    logic          prev;
    logic          trans;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic [GW-1:0] good, good_nxt;
    logic [CW-1:0] last_nxt;

    assign trans   = div_clk ^ prev;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        good_nxt  = good;
        last_nxt  = last_meas;
        if (CLR) begin
            // Clear wins over anything detected this cycle; partial interval is dropped.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            good_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trans) begin
                        state_nxt = TRACK;
                        cnt_nxt   = CW'(1);
                    end
                end
                TRACK: begin
                    if (trans) begin
                        last_nxt = cnt;
                        cnt_nxt  = CW'(1);
                        if (cnt == HP_V) begin
                            good_nxt = (good == GOOD_MAX) ? good : good + GW'(1);
                        end else begin
                            state_nxt = FAULT;
                            good_nxt  = '0;
                        end
                    end else if (cnt >= HP1_V) begin
                        // Stuck or slow: no edge by HP+1, report the overrun length.
                        last_nxt  = HP1_V;
                        state_nxt = FAULT;
                        good_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                FAULT: begin
                    cnt_nxt  = '0;
                    good_nxt = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            state     <= IDLE;
            prev      <= 1'b0;
            cnt       <= '0;
            good      <= '0;
            last_meas <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= div_clk;
            cnt       <= cnt_nxt;
            good      <= good_nxt;
            last_meas <= last_nxt;
        end
    end

    assign err      = (state == FAULT);
    assign lock_nxt = (state_nxt == TRACK) && (good_nxt == GOOD_MAX);

endmodule

// File: rtl/freq_div_monitor.sv
// Checks the three freq_div outputs for correct half-periods; sticky per-channel ERR, LOCK and MEAS readback.
// ERR/LOCK update on the detection edge; MEAS follows MEAS_SEL one cycle later.
// No backpressure: inputs sampled every CLK_in cycle.
module freq_div_monitor
    import freq_div_pkg::*;
#(
    parameter int HP_50  = 1,
    parameter int HP_10  = 5,
    parameter int HP_1   = 50,
    parameter int LOCK_N = 4,
    parameter int CW     = 8
) (
    input  logic          CLK_in,
    input  logic          RST,
    input  logic          CLK_50,
    input  logic          CLK_10,
    input  logic          CLK_1,
    input  logic          CLR,
    input  logic [1:0]    MEAS_SEL,
    output logic [2:0]    ERR,
    output logic          LOCK,
    output logic [CW-1:0] MEAS
);

    logic [N_CH-1:0] ok_nxt;
    logic [CW-1:0]   meas_50, meas_10, meas_1;
    logic [CW-1:0]   meas_nxt;

    freq_div_chan_mon #(.HP(HP_50), .LOCK_N(LOCK_N), .CW(CW)) u_ch_50 (
        .CLK_in    (CLK_in),
        .RST       (RST),
        .div_clk   (CLK_50),
        .CLR       (CLR),
        .err       (ERR[CH_50]),
        .lock_nxt  (ok_nxt[CH_50]),
        .last_meas (meas_50)
    );

    freq_div_chan_mon #(.HP(HP_10), .LOCK_N(LOCK_N), .CW(CW)) u_ch_10 (
        .CLK_in    (CLK_in),
        .RST       (RST),
        .div_clk   (CLK_10),
        .CLR       (CLR),
        .err       (ERR[CH_10]),
        .lock_nxt  (ok_nxt[CH_10]),
        .last_meas (meas_10)
    );

    freq_div_chan_mon #(.HP(HP_1), .LOCK_N(LOCK_N), .CW(CW)) u_ch_1 (
        .CLK_in    (CLK_in),
        .RST       (RST),
        .div_clk   (CLK_1),
        .CLR       (CLR),
        .err       (ERR[CH_1]),
        .lock_nxt  (ok_nxt[CH_1]),
        .last_meas (meas_1)
    );

    always_comb begin
        meas_nxt = '0;
        case (MEAS_SEL)
            2'd0:    meas_nxt = meas_50;
            2'd1:    meas_nxt = meas_10;
            2'd2:    meas_nxt = meas_1;
            default: meas_nxt = '0;
        endcase
    end

    // LOCK is built from next-state terms so it drops on the same edge ERR rises.
    always_ff @(posedge CLK_in) begin
        if (RST) begin
            LOCK <= 1'b0;
            MEAS <= '0;
        end else begin
            LOCK <= &ok_nxt;
            MEAS <= meas_nxt;
        end
    end

endmodule

// File: tb/tb_freq_div_monitor.sv
// Randomized bench for freq_div_monitor: timestamp-based reference model feeds a scoreboard queue.
module tb_freq_div_monitor;

    localparam int LOCK_N = 4;
    localparam int CW     = 8;

    logic          CLK_in = 1'b0;
    logic          RST = 1'b1;
    logic          CLK_50 = 1'b0;
    logic          CLK_10 = 1'b0;
    logic          CLK_1 = 1'b0;
    logic          CLR = 1'b0;
    logic [1:0]    MEAS_SEL = 2'd0;
    logic [2:0]    ERR;
    logic          LOCK;
    logic [CW-1:0] MEAS;

    freq_div_monitor #(.HP_50(1), .HP_10(5), .HP_1(50), .LOCK_N(LOCK_N), .CW(CW)) dut (
        .CLK_in   (CLK_in),
        .RST      (RST),
        .CLK_50   (CLK_50),
        .CLK_10   (CLK_10),
        .CLK_1    (CLK_1),
        .CLR      (CLR),
        .MEAS_SEL (MEAS_SEL),
        .ERR      (ERR),
        .LOCK     (LOCK),
        .MEAS     (MEAS)
    );

    always #5 CLK_in = ~CLK_in;

    typedef struct packed {
        logic [2:0]    err;
        logic          lock;
        logic [CW-1:0] meas;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // waveform generator (stands in for freq_div)
    int         hp_ideal[3] = '{1, 5, 50};
    int         hp_use[3];
    int         rem[3];
    bit         hold[3];
    logic [2:0] lvl;
    int         sel_fix = -1;

    // reference model: transition timestamps per channel
    bit         m_started[3];
    bit         m_faulted[3];
    int         m_tlast[3];
    int         m_good[3];
    int         m_last[3];
    logic [2:0] m_prev;
    int         m_meas;
    bit         m_lock;
    int         edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic clr, input logic [2:0] x, input logic [1:0] sel);
        exp_t e;
        int   len;
        edge_n++;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_started[i] = 0; m_faulted[i] = 0; m_good[i] = 0; m_last[i] = 0; m_tlast[i] = 0;
            end
            m_prev = 3'b000;
            m_meas = 0;
            m_lock = 0;
        end else begin
            m_meas = (sel == 2'd3) ? 0 : m_last[sel];
            for (int i = 0; i < 3; i++) begin
                if (clr) begin
                    m_started[i] = 0; m_faulted[i] = 0; m_good[i] = 0;
                end else if (m_faulted[i]) begin
                    m_good[i] = 0;
                end else if (!m_started[i]) begin
                    if (x[i] != m_prev[i]) begin
                        m_started[i] = 1;
                        m_tlast[i]   = edge_n;
                    end
                end else begin
                    len = edge_n - m_tlast[i];
                    if (x[i] != m_prev[i]) begin
                        m_last[i]  = len;
                        m_tlast[i] = edge_n;
                        if (len == hp_ideal[i]) m_good[i] = (m_good[i] < LOCK_N) ? m_good[i] + 1 : LOCK_N;
                        else begin m_faulted[i] = 1; m_good[i] = 0; end
                    end else if (len == hp_ideal[i] + 1) begin
                        m_last[i]    = len;
                        m_faulted[i] = 1;
                        m_good[i]    = 0;
                    end
                end
            end
            m_prev = x;
            m_lock = 1;
            for (int i = 0; i < 3; i++)
                if (!m_started[i] || m_faulted[i] || m_good[i] != LOCK_N) m_lock = 0;
        end
        e.err  = {m_faulted[2], m_faulted[1], m_faulted[0]};
        e.lock = m_lock;
        e.meas = CW'(m_meas);
        sb_q.push_back(e);
    endtask

    task automatic advance();
        for (int i = 0; i < 3; i++) begin
            if (!hold[i]) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = hp_use[i];
                end
            end
        end
    endtask

    task automatic tick(input logic rst, input logic clr);
        if (!rst) advance();
        CLK_50   = lvl[0];
        CLK_10   = lvl[1];
        CLK_1    = lvl[2];
        RST      = rst;
        CLR      = clr;
        MEAS_SEL = (sel_fix >= 0) ? 2'(sel_fix) : 2'($urandom_range(0, 3));
        @(posedge CLK_in);
        model_step(rst, clr, {CLK_1, CLK_10, CLK_50}, MEAS_SEL);
        #1;
    endtask

    task automatic restart_gen();
        lvl = 3'b000;
        for (int i = 0; i < 3; i++) begin
            rem[i] = hp_ideal[i]; hp_use[i] = hp_ideal[i]; hold[i] = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    always @(negedge CLK_in) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_err",  32'(ERR),  32'(mon_e.err));
            check("sb_lock", 32'(LOCK), 32'(mon_e.lock));
            check("sb_meas", 32'(MEAS), 32'(mon_e.meas));
        end
    end

    initial begin
        int guard;
        int r;
        int ch;

        // 1: ideal waveforms from reset
        restart_gen();
        repeat (3) tick(1'b1, 1'b0);
        check("rst_err",  32'(ERR),  32'd0);
        check("rst_lock", 32'(LOCK), 32'd0);
        check("rst_meas", 32'(MEAS), 32'd0);
        run(300);
        check("t1_lock", 32'(LOCK), 32'd1);
        check("t1_err",  32'(ERR),  32'd0);

        // 2: CLK_10 at half-period 4
        hp_use[1] = 4;
        sel_fix   = 1;
        run(20);
        check("t2_err",  32'(ERR),  32'b010);
        check("t2_lock", 32'(LOCK), 32'd0);
        check("t2_meas", 32'(MEAS), 32'd4);

        // 3: lock, then CLK_1 stuck low
        sel_fix = -1;
        restart_gen();
        repeat (2) tick(1'b1, 1'b0);
        run(300);
        check("t3_pre_lock", 32'(LOCK), 32'd1);
        hold[2] = 1;
        lvl[2]  = 1'b0;
        sel_fix = 2;
        run(60);
        check("t3_err",  32'(ERR),  32'b100);
        check("t3_lock", 32'(LOCK), 32'd0);
        check("t3_meas", 32'(MEAS), 32'd51);

        // 4: CLR recovery with ideal waveforms
        hold[2] = 0;
        sel_fix = -1;
        tick(1'b0, 1'b1);
        check("t4_err",  32'(ERR),  32'd0);
        check("t4_lock", 32'(LOCK), 32'd0);
        run(300);
        check("t4_relock", 32'(LOCK), 32'd1);

        // 5: RST mid-interval while locked
        run(23);
        restart_gen();
        tick(1'b1, 1'b0);
        check("t5_err",  32'(ERR),  32'd0);
        check("t5_lock", 32'(LOCK), 32'd0);
        check("t5_meas", 32'(MEAS), 32'd0);
        run(300);
        check("t5_relock", 32'(LOCK), 32'd1);
        check("t5_err2",   32'(ERR),  32'd0);

        // 6: CLR in the same cycle as an early CLK_10 edge
        guard = 0;
        while (rem[1] != 3 && guard < 20) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        rem[1] = 1;
        tick(1'b0, 1'b1);
        check("t6_err", 32'(ERR), 32'd0);
        run(300);
        check("t6_lock", 32'(LOCK), 32'd1);
        check("t6_err2", 32'(ERR),  32'd0);

        // 7: randomized jitter, stalls, clears and resets
        for (int k = 0; k < 2500; k++) begin
            r = $urandom_range(0, 999);
            if (r < 5) begin
                tick(1'b1, 1'b0);
            end else if (r < 15) begin
                tick(1'b0, 1'b1);
            end else begin
                if ($urandom_range(0, 99) < 3) begin
                    ch = $urandom_range(0, 2);
                    hp_use[ch] = hp_ideal[ch] + $urandom_range(0, 2) - 1;
                    if (hp_use[ch] < 1) hp_use[ch] = 1;
                end
                if ($urandom_range(0, 199) == 0) begin
                    ch = $urandom_range(0, 2);
                    hold[ch] = ~hold[ch];
                end
                if ($urandom_range(0, 99) < 2) begin
                    for (int i = 0; i < 3; i++) begin
                        hp_use[i] = hp_ideal[i]; hold[i] = 0;
                    end
                end
                tick(1'b0, 1'b0);
            end
        end

        @(negedge CLK_in);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
